// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic tile block sequencer.
package systolic_pkg;

  localparam int BLOCK_LEN  = 16;
  localparam int PIPE_DEPTH = 16;
  localparam int CW         = 4;

  // Slot positions of the control bit within one block frame.
  localparam int SLOT_VALID = 0;
  localparam int SLOT_OP    = 1;
  localparam int SLOT_GAP   = BLOCK_LEN - 1;

  typedef enum logic {
    OP_FMA = 1'b0,
    OP_XOR = 1'b1
  } op_e;

endpackage

// File: rtl/systolic_shift_tracker.sv
// Capture / shift-done tracking for one control stream (column or row).
module systolic_shift_tracker #(
  parameter int BLOCK_LEN = 16,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [CW-1:0] count_i,
  input  logic          ctrl_i,
  input  logic          clear_i,
  input  logic          abort_i,
  output logic          capture_o,
  output logic          done_o,
  output logic          done_eff_o
);
  import systolic_pkg::*;

  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  logic cap_q, cap_d;
  logic done_q, done_d;
  logic at_valid, at_gap;

  assign at_valid = (count_i == CW'(SLOT_VALID));
  assign at_gap   = (count_i == LAST);

  // A block is only taken when the previous vector has been consumed.
  assign capture_o  = rst_n & (at_valid ? (ctrl_i & ~done_q) : cap_q);
  assign done_o     = done_q;
  assign done_eff_o = done_q | (at_gap & cap_q & ~abort_i);

  always_comb begin
    cap_d  = cap_q;
    done_d = done_q;
    if (at_valid) begin
      cap_d = ctrl_i & ~done_q;
    end else if (at_gap && abort_i) begin
      cap_d = 1'b0;
    end
    // Clear from a start beats a completion landing in the same cycle.
    if (clear_i) begin
      done_d = 1'b0;
    end else if (at_gap && cap_q && !abort_i) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (ena) begin
      cap_q  <= cap_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/systolic_block_sequencer.sv
// Block counter, A/B capture control and MAC pipeline start sequencing for one tile.
// Optional gap-cycle framing check enabled by SYSTOLIC_SEQ_FRAME_CHECK_EN.
module systolic_block_sequencer #(
  parameter int BLOCK_LEN  = systolic_pkg::BLOCK_LEN,
  parameter int PIPE_DEPTH = systolic_pkg::PIPE_DEPTH,
  parameter int CW         = systolic_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          col_ctrl_in,
  input  logic          row_ctrl_in,
  output logic [CW-1:0] count,
  output logic          col_capture,
  output logic          row_capture,
  output logic          col_shift_done,
  output logic          row_shift_done,
  output logic          mac_start,
  output logic          op_xor,
  output logic          pipe_busy,
  output logic [CW-1:0] pipe_count,
  output logic          continuous,
  output logic          stall
`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
  ,
  output logic          frame_err
`endif
);
  import systolic_pkg::*;

  localparam logic [CW-1:0] LAST      = CW'(BLOCK_LEN - 1);
  localparam int            PW        = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [PW-1:0] PIPE_LAST = PW'(PIPE_DEPTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pipe_q, pipe_d;
  logic          busy_q, busy_d;
  logic          cont_q, cont_d;
  op_e           op_q, op_d;
  op_e           pend_q, pend_d;

  logic at_gap, gap_err, ready, pipe_free, start;
  logic col_eff, row_eff;

  assign at_gap = (count_q == LAST);

`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
  logic frame_err_q;
  assign gap_err   = ena & at_gap & (col_ctrl_in | row_ctrl_in);
  assign frame_err = frame_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else if (gap_err) begin
      frame_err_q <= 1'b1;
    end
  end
`else
  assign gap_err = 1'b0;
`endif

  systolic_shift_tracker #(.BLOCK_LEN(BLOCK_LEN), .CW(CW)) u_col (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .count_i    (count_q),
    .ctrl_i     (col_ctrl_in),
    .clear_i    (start),
    .abort_i    (gap_err),
    .capture_o  (col_capture),
    .done_o     (col_shift_done),
    .done_eff_o (col_eff)
  );

  systolic_shift_tracker #(.BLOCK_LEN(BLOCK_LEN), .CW(CW)) u_row (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .count_i    (count_q),
    .ctrl_i     (row_ctrl_in),
    .clear_i    (start),
    .abort_i    (gap_err),
    .capture_o  (row_capture),
    .done_o     (row_shift_done),
    .done_eff_o (row_eff)
  );

  // The retiring stage may hand over directly to a new start.
  assign ready     = at_gap & col_eff & row_eff;
  assign pipe_free = ~busy_q | (pipe_q == PIPE_LAST);
  assign start     = rst_n & ena & ready & pipe_free;
  assign mac_start = start;
  assign stall     = rst_n & ena & ready & ~pipe_free;

  assign count      = count_q;
  assign pipe_count = CW'(pipe_q);
  assign pipe_busy  = busy_q;
  assign continuous = cont_q;
  assign op_xor     = (op_q == OP_XOR);

  always_comb begin
    // A gap-cycle framing error also lands on 0, which is the natural wrap.
    count_d = at_gap ? '0 : count_q + 1'b1;
    pend_d  = pend_q;
    op_d    = op_q;
    busy_d  = busy_q;
    pipe_d  = pipe_q;
    cont_d  = cont_q;
    // Op bit belongs to the A vector, so only a captured column block sets it.
    if (count_q == CW'(SLOT_OP) && col_capture) begin
      pend_d = op_e'(col_ctrl_in);
    end
    if (start) begin
      op_d   = pend_q;
      busy_d = 1'b1;
      pipe_d = '0;
      cont_d = busy_q & (pipe_q == PIPE_LAST);
    end else if (busy_q) begin
      if (pipe_q == PIPE_LAST) begin
        busy_d = 1'b0;
        pipe_d = '0;
        cont_d = 1'b0;
      end else begin
        pipe_d = pipe_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      pipe_q  <= '0;
      busy_q  <= 1'b0;
      cont_q  <= 1'b0;
      op_q    <= OP_FMA;
      pend_q  <= OP_FMA;
    end else if (ena) begin
      count_q <= count_d;
      pipe_q  <= pipe_d;
      busy_q  <= busy_d;
      cont_q  <= cont_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_systolic_block_sequencer.sv
// Randomized bench for systolic_block_sequencer with a behavioural block/pipeline model;
// instance 0 uses default depth, instance 1 a deeper pipeline so that stalls occur.
module tb_systolic_block_sequencer;

  localparam int L   = 16;
  localparam int PD0 = 16;
  localparam int PD1 = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic col = 1'b0;
  logic row = 1'b0;

  always #5 clk = ~clk;

  logic [1:0][3:0] o_count, o_pcount;
  logic [1:0] o_ccap, o_rcap, o_csd, o_rsd, o_ms, o_ox, o_pb, o_ct, o_st;
`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
  logic [1:0] o_fe;
`endif

  systolic_block_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .col_ctrl_in(col), .row_ctrl_in(row),
    .count(o_count[0]), .col_capture(o_ccap[0]), .row_capture(o_rcap[0]),
    .col_shift_done(o_csd[0]), .row_shift_done(o_rsd[0]), .mac_start(o_ms[0]),
    .op_xor(o_ox[0]), .pipe_busy(o_pb[0]), .pipe_count(o_pcount[0]),
    .continuous(o_ct[0]), .stall(o_st[0])
`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
    , .frame_err(o_fe[0])
`endif
  );

  systolic_block_sequencer #(.PIPE_DEPTH(PD1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .col_ctrl_in(col), .row_ctrl_in(row),
    .count(o_count[1]), .col_capture(o_ccap[1]), .row_capture(o_rcap[1]),
    .col_shift_done(o_csd[1]), .row_shift_done(o_rsd[1]), .mac_start(o_ms[1]),
    .op_xor(o_ox[1]), .pipe_busy(o_pb[1]), .pipe_count(o_pcount[1]),
    .continuous(o_ct[1]), .stall(o_st[1])
`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
    , .frame_err(o_fe[1])
`endif
  );

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  chk_on = 1'b0;
  bit  dir_on = 1'b0;

  // Behavioural model: loaded vectors, current-block ownership, pipeline age.
  int  m_pos[2];
  int  m_age[2];
  bit  m_a_ld[2], m_b_ld[2], m_a_cur[2], m_b_cur[2];
  bit  m_op_pend[2], m_op_cur[2], m_cont[2], m_ferr[2];

  function automatic int pd(input int k);
    return (k == 0) ? PD0 : PD1;
  endfunction

  // Both instances see the same stimulus and reset, so block position is shared.
  function automatic bit m_gap();
`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
    return ena && (m_pos[0] == L - 1) && (col || row);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready(input int k);
    bit a_ok, b_ok;
    a_ok = m_a_ld[k] || (m_a_cur[k] && !m_gap());
    b_ok = m_b_ld[k] || (m_b_cur[k] && !m_gap());
    return (m_pos[k] == L - 1) && a_ok && b_ok;
  endfunction

  function automatic bit m_free(input int k);
    return (m_age[k] < 0) || (m_age[k] == pd(k) - 1);
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%0d expected=%0d", nm, k, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit rd, st, ge;
    if (dir_on) cyc = cyc + 1;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pos[k] = 0; m_age[k] = -1;
        m_a_ld[k] = 0; m_b_ld[k] = 0; m_a_cur[k] = 0; m_b_cur[k] = 0;
        m_op_pend[k] = 0; m_op_cur[k] = 0; m_cont[k] = 0; m_ferr[k] = 0;
      end
    end else if (ena) begin
      ge = m_gap();
      for (int k = 0; k < 2; k++) begin
        rd = m_ready(k);
        st = rd && m_free(k);
        if (m_pos[k] == 0) begin
          m_a_cur[k] = col && !m_a_ld[k];
          m_b_cur[k] = row && !m_b_ld[k];
        end
        if (m_pos[k] == 1 && m_a_cur[k]) m_op_pend[k] = col;
        if (m_pos[k] == L - 1) begin
          if (ge) begin
            m_a_cur[k] = 0; m_b_cur[k] = 0; m_ferr[k] = 1;
          end else begin
            m_a_ld[k] = m_a_ld[k] | m_a_cur[k];
            m_b_ld[k] = m_b_ld[k] | m_b_cur[k];
          end
        end
        if (st) begin
          m_a_ld[k] = 0; m_b_ld[k] = 0;
          m_op_cur[k] = m_op_pend[k];
          m_cont[k] = (m_age[k] == pd(k) - 1);
          m_age[k] = 0;
        end else if (m_age[k] >= 0) begin
          if (m_age[k] == pd(k) - 1) begin
            m_age[k] = -1; m_cont[k] = 0;
          end else begin
            m_age[k] = m_age[k] + 1;
          end
        end
        m_pos[k] = (m_pos[k] + 1) % L;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        bit rd, fr;
        rd = m_ready(k);
        fr = m_free(k);
        chk("count", k, o_count[k], m_pos[k]);
        chk("col_capture", k, o_ccap[k],
            rst_n ? ((m_pos[k] == 0) ? (col && !m_a_ld[k]) : m_a_cur[k]) : 0);
        chk("row_capture", k, o_rcap[k],
            rst_n ? ((m_pos[k] == 0) ? (row && !m_b_ld[k]) : m_b_cur[k]) : 0);
        chk("col_shift_done", k, o_csd[k], m_a_ld[k]);
        chk("row_shift_done", k, o_rsd[k], m_b_ld[k]);
        chk("mac_start", k, o_ms[k], rst_n && ena && rd && fr);
        chk("stall", k, o_st[k], rst_n && ena && rd && !fr);
        chk("op_xor", k, o_ox[k], m_op_cur[k]);
        chk("pipe_busy", k, o_pb[k], m_age[k] >= 0);
        chk("pipe_count", k, o_pcount[k], (m_age[k] < 0) ? 0 : (m_age[k] % 16));
        chk("continuous", k, o_ct[k], m_cont[k]);
`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
        chk("frame_err", k, o_fe[k], m_ferr[k]);
`endif
      end
    end
  end

  // Hand-computed expectations for the directed five-block sequence.
  always @(negedge clk) begin
    if (dir_on) begin
      case (cyc)
        0:  begin chk("lit_ccap_b0", 0, o_ccap[0], 1); chk("lit_rcap_b0", 0, o_rcap[0], 1); end
        5:  chk("lit_count5", 0, o_count[0], 5);
        15: begin chk("lit_start_b0", 0, o_ms[0], 1); chk("lit_nostall_b0", 0, o_st[0], 0); end
        16: begin
              chk("lit_busy", 0, o_pb[0], 1); chk("lit_pc0", 0, o_pcount[0], 0);
              chk("lit_cont0", 0, o_ct[0], 0); chk("lit_op_fma", 0, o_ox[0], 0);
              chk("lit_csd_clr", 0, o_csd[0], 0); chk("lit_wrap", 0, o_count[0], 0);
            end
        31: begin
              chk("lit_start_b1", 0, o_ms[0], 1); chk("lit_pc15", 0, o_pcount[0], 15);
              chk("lit_stall", 1, o_st[1], 1); chk("lit_nostart", 1, o_ms[1], 0);
            end
        32: begin
              chk("lit_cont1", 0, o_ct[0], 1); chk("lit_op_xor", 0, o_ox[0], 1);
              chk("lit_pass", 1, o_ccap[1], 0); chk("lit_csd_held", 1, o_csd[1], 1);
              chk("lit_rsd_held", 1, o_rsd[1], 1);
            end
        40: chk("lit_idle", 1, o_pb[1], 0);
        47: begin chk("lit_col_only", 0, o_ms[0], 0); chk("lit_deferred", 1, o_ms[1], 1); end
        48: begin
              chk("lit_retire", 0, o_pb[0], 0); chk("lit_col_wait", 0, o_csd[0], 1);
              chk("lit_pass2", 0, o_ccap[0], 0); chk("lit_def_op", 1, o_ox[1], 1);
              chk("lit_recap", 1, o_ccap[1], 1);
            end
        64: chk("lit_row_b4", 0, o_rcap[0], 1);
        79: begin chk("lit_start_b4", 0, o_ms[0], 1); chk("lit_start_b4", 1, o_ms[1], 1); end
        80: chk("lit_op_b2", 0, o_ox[0], 0);
        default: ;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1);
  end

  initial begin
    bit found;
    bit vc[5] = '{1, 1, 1, 1, 1};
    bit vr[5] = '{1, 1, 0, 0, 1};
    bit vo[5] = '{0, 1, 0, 0, 0};
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 0, o_count[0], 0);
    chk("rst_busy", 0, o_pb[0], 0);

    // Directed: five blocks from a known frame start, then an idle block.
    rst_n = 1'b1; ena = 1'b1; dir_on = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < L; i++) begin
        col = (b < 5) && ((i == 0) ? vc[b] : (i == 1) ? vo[b] : 1'b0);
        row = (b < 5) && (i == 0) && vr[b];
        @(posedge clk); #1;
      end
    end
    dir_on = 1'b0;

    // Enable low freezes everything.
    ena = 1'b0;
    repeat (6) begin
      col = $urandom_range(0, 1); row = $urandom_range(0, 1);
      @(posedge clk); #1;
    end

    // Randomized traffic; the gap slot always carries 0.
    for (int n = 0; n < 3000; n++) begin
      ena = ($urandom_range(0, 9) != 0);
      if (m_pos[0] == 0) begin
        col = ($urandom_range(0, 9) < 6); row = ($urandom_range(0, 9) < 6);
      end else if (m_pos[0] == L - 1) begin
        col = 1'b0; row = 1'b0;
      end else begin
        col = $urandom_range(0, 1); row = $urandom_range(0, 1);
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of a pipeline run.
    ena = 1'b1; found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (m_age[0] == 5) begin
        found = 1'b1;
      end else begin
        col = (m_pos[0] == 0); row = (m_pos[0] == 0);
        @(posedge clk); #1;
      end
    end
    chk("midpipe_reached", 0, found, 1);
    col = 1'b0; row = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 0, o_pb[0], 0);
    chk("midrst_pc", 0, o_pcount[0], 0);
    chk("midrst_count", 0, o_count[0], 0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

`ifdef SYSTOLIC_SEQ_FRAME_CHECK_EN
    // Control high in the gap cycle.
    col = 1'b1; row = 1'b1;
    @(posedge clk); #1;
    col = 1'b0; row = 1'b0;
    for (int n = 0; n < 2 * L && m_pos[0] != L - 1; n++) begin
      @(posedge clk); #1;
    end
    col = 1'b1;
    @(posedge clk); #1;
    col = 1'b0;
    chk("ferr_set", 0, o_fe[0], 1);
    chk("ferr_resync", 0, o_count[0], 0);
    repeat (20) @(posedge clk);
    #1;
`endif

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
